// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC dot-product sequencer and its lane bank.
package mac_pkg;

  localparam int MAC_LAT = 3;
  localparam int ACC_W   = 32;
  localparam int OP_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    DRAIN,
    REDUCE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/lane_acc_bank.sv
// Interleaved partial accumulators with per-lane in-flight flags.
// Each lane is written when its MAC result returns, and it can be read by index.
module lane_acc_bank
  import mac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_set_busy,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic             i_ret_valid,
  input  logic [IDX_W-1:0] i_ret_idx,
  input  logic [ACC_W-1:0] i_ret_data,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [ACC_W-1:0] o_rd_data,
  output logic [LANES-1:0] o_busy
);

  logic [ACC_W-1:0] r_partial [LANES];
  logic [LANES-1:0] r_busy;
  logic [LANES-1:0] w_set_mask;
  logic [LANES-1:0] w_ret_mask;

  assign w_set_mask = i_set_busy  ? (LANES'(1) << i_set_idx) : '0;
  assign w_ret_mask = i_ret_valid ? (LANES'(1) << i_ret_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) r_partial[i] <= '0;
      r_busy <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < LANES; i++) r_partial[i] <= '0;
      r_busy <= '0;
    end else begin
      if (i_ret_valid) r_partial[i_ret_idx] <= i_ret_data;
      // Set and clear never target the same lane: an issue needs the lane idle, a return needs it busy.
      r_busy <= (r_busy | w_set_mask) & ~w_ret_mask;
    end
  end

  assign o_rd_data = r_partial[i_rd_idx];
  assign o_busy    = r_busy;

endmodule

// File: rtl/mac_dot_sequencer.sv
// Streams N operand pairs into a 3-stage MAC, interleaving accumulator feedback
// across LANES partials, then reduces the partials into one 32-bit result.
//
// state  | meaning
// IDLE   | waiting for a command; cmd_ready high
// STREAM | issuing operand pairs to the MAC
// DRAIN  | waiting for the remaining MAC returns
// REDUCE | summing the lane partials, one lane per cycle
// DONE   | result held until res_ready
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [OP_W-1:0]    op_a,
  input  logic [OP_W-1:0]    op_b,
  output logic               mac_in_valid,
  output logic [OP_W-1:0]    mac_a,
  output logic [OP_W-1:0]    mac_b,
  output logic [ACC_W-1:0]   mac_acc,
  input  logic               mac_out_valid,
  input  logic [ACC_W-1:0]   mac_y,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_data,
  output logic               busy
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issued;
  logic [LEN_W-1:0] r_returned;
  logic [IDX_W-1:0] r_iss_ptr;
  logic [IDX_W-1:0] r_ret_ptr;
  logic [IDX_W-1:0] r_red_idx;

  logic             r_mac_in_valid;
  logic [OP_W-1:0]  r_mac_a;
  logic [OP_W-1:0]  r_mac_b;
  logic [ACC_W-1:0] r_mac_acc;
  logic [ACC_W-1:0] r_res_data;

  logic             w_cmd_hs;
  logic             w_op_hs;
  logic             w_op_ready;
  logic             w_ret;
  logic [LANES-1:0] w_busy;
  logic [IDX_W-1:0] w_rd_idx;
  logic [ACC_W-1:0] w_rd_data;

  lane_acc_bank #(
    .LANES (LANES),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_cmd_hs),
    .i_set_busy  (w_op_hs),
    .i_set_idx   (r_iss_ptr),
    .i_ret_valid (w_ret),
    .i_ret_idx   (r_ret_ptr),
    .i_ret_data  (mac_y),
    .i_rd_idx    (w_rd_idx),
    .o_rd_data   (w_rd_data),
    .o_busy      (w_busy)
  );

  assign w_op_ready = (r_state == STREAM) && !w_busy[r_iss_ptr] && (r_issued < r_len);
  // Returns arriving with no lane outstanding (e.g. noise after a reset) are dropped.
  assign w_ret      = mac_out_valid && w_busy[r_ret_ptr];
  assign w_rd_idx   = (r_state == REDUCE) ? r_red_idx : r_iss_ptr;

  always_comb begin
    w_next   = r_state;
    w_cmd_hs = 1'b0;
    w_op_hs  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_cmd_hs = 1'b1;
          w_next   = (cmd_len == '0) ? REDUCE : STREAM;
        end
      end
      STREAM: begin
        w_op_hs = op_valid && w_op_ready;
        if (r_issued == r_len) w_next = DRAIN;
      end
      DRAIN:   if (r_returned == r_len) w_next = REDUCE;
      REDUCE:  if (r_red_idx == LAST_LANE) w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_len          <= '0;
      r_issued       <= '0;
      r_returned     <= '0;
      r_iss_ptr      <= '0;
      r_ret_ptr      <= '0;
      r_red_idx      <= '0;
      r_mac_in_valid <= 1'b0;
      r_mac_a        <= '0;
      r_mac_b        <= '0;
      r_mac_acc      <= '0;
      r_res_data     <= '0;
    end else begin
      r_state        <= w_next;
      r_mac_in_valid <= w_op_hs;
      if (w_op_hs) begin
        r_mac_a   <= op_a;
        r_mac_b   <= op_b;
        r_mac_acc <= w_rd_data;
        r_issued  <= r_issued + LEN_W'(1);
        r_iss_ptr <= (r_iss_ptr == LAST_LANE) ? '0 : r_iss_ptr + IDX_W'(1);
      end
      if (w_ret) begin
        r_returned <= r_returned + LEN_W'(1);
        r_ret_ptr  <= (r_ret_ptr == LAST_LANE) ? '0 : r_ret_ptr + IDX_W'(1);
      end
      if (r_state == REDUCE) begin
        r_res_data <= r_res_data + w_rd_data;
        r_red_idx  <= (r_red_idx == LAST_LANE) ? '0 : r_red_idx + IDX_W'(1);
      end
      if (w_cmd_hs) begin
        r_len      <= cmd_len;
        r_issued   <= '0;
        r_returned <= '0;
        r_iss_ptr  <= '0;
        r_ret_ptr  <= '0;
        r_red_idx  <= '0;
        r_res_data <= '0;
      end
    end
  end

  assign cmd_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign res_valid    = (r_state == DONE);
  assign op_ready     = w_op_ready;
  assign mac_in_valid = r_mac_in_valid;
  assign mac_a        = r_mac_a;
  assign mac_b        = r_mac_b;
  assign mac_acc      = r_mac_acc;
  assign res_data     = r_res_data;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer driving a 3-stage signed MAC responder.
module tb_mac_dot_sequencer;
  localparam int LEN_W = 16;
  localparam int LANES = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             mac_in_valid;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic [31:0]      mac_acc;
  logic             mac_out_valid;
  logic [31:0]      mac_y;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic             busy;

  int tests = 0;
  int fails = 0;
  int va [16];
  int vb [16];
  int pulses, run, maxrun, outst, maxout;

  mac_dot_sequencer #(.LEN_W(LEN_W), .LANES(LANES)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .mac_in_valid  (mac_in_valid),
    .mac_a         (mac_a),
    .mac_b         (mac_b),
    .mac_acc       (mac_acc),
    .mac_out_valid (mac_out_valid),
    .mac_y         (mac_y),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // MAC responder: y = acc + a*b, three register stages, reset by rst_n = ~rst
  logic        mac_rst_n;
  logic        s1_v, s2_v;
  logic [31:0] s1_y, s2_y;
  assign mac_rst_n = ~rst;

  always_ff @(posedge clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      s1_v <= 1'b0; s1_y <= '0;
      s2_v <= 1'b0; s2_y <= '0;
      mac_out_valid <= 1'b0; mac_y <= '0;
    end else begin
      s1_v <= mac_in_valid;
      s1_y <= $signed(mac_acc) + $signed(mac_a) * $signed(mac_b);
      s2_v <= s1_v;
      s2_y <= s1_y;
      mac_out_valid <= s2_v;
      mac_y <= s2_y;
    end
  end

  always @(posedge clk) begin
    if (mac_in_valid) begin
      pulses++;
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    outst = outst + int'(mac_in_valid) - int'(mac_out_valid);
    if (outst > maxout) maxout = outst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_dot(input string tag, input int n, input bit gap, input int hold,
                         input logic [31:0] exp_res, input int exp_lat);
    int idx, lat;
    bit got, tog, stable;
    logic [31:0] held;
    @(negedge clk);
    pulses = 0; run = 0; maxrun = 0; outst = 0; maxout = 0;
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_len   = n[LEN_W-1:0];
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_len   = '0;
    idx = 0; lat = 0; got = 1'b0; tog = 1'b1;
    while (!got && lat < 400) begin
      if (res_valid) begin
        got = 1'b1;
      end else begin
        if (idx < n) begin
          op_valid = gap ? tog : 1'b1;
          op_a = va[idx][7:0];
          op_b = vb[idx][7:0];
          tog = !tog;
        end else begin
          op_valid = 1'b0;
        end
        if (op_valid && op_ready) idx++;
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    op_valid = 1'b0;
    chk({tag, "_res_valid"}, 32'(got), 32'd1);
    if (exp_lat >= 0) chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_res_data"}, res_data, exp_res);
    chk({tag, "_mac_pulses"}, pulses, n);
    chk({tag, "_cmd_ready_busy"}, {30'd0, cmd_ready, busy}, 32'b01);
    held = res_data;
    stable = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      if (!res_valid || res_data !== held || cmd_ready) stable = 1'b0;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_res_valid_drop"}, 32'(res_valid), 32'd0);
    chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_len = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0;
    res_ready = 1'b0;
    pulses = 0; run = 0; maxrun = 0; outst = 0; maxout = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {27'd0, cmd_ready, busy, op_ready, mac_in_valid, res_valid}, 32'b10000);
    chk("reset_mac_ab", {16'd0, mac_a, mac_b}, 32'd0);
    chk("reset_mac_acc", mac_acc, 32'd0);
    chk("reset_res_data", res_data, 32'd0);
    rst = 1'b0;

    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
    vb[0] = 5; vb[1] = 6; vb[2] = 7; vb[3] = 8;
    run_dot("basic", 4, 1'b0, 0, 32'd70, 13);
    chk("basic_consecutive", maxrun, 4);

    va[0] = -128; va[1] = -128;
    vb[0] = -128; vb[1] = 127;
    run_dot("signed2", 2, 1'b0, 0, 32'd128, 11);

    va[0] = -1; vb[0] = 5;
    run_dot("neg1", 1, 1'b0, 0, 32'hFFFF_FFFB, 10);

    for (int i = 0; i < 9; i++) begin va[i] = 3; vb[i] = -2; end
    run_dot("gapped", 9, 1'b1, 0, 32'hFFFF_FFCA, -1);
    chk("gapped_max_inflight", 32'(maxout <= LANES), 32'd1);

    run_dot("zero", 0, 1'b0, 0, 32'd0, 4);

    for (int i = 0; i < 3; i++) begin va[i] = 1; vb[i] = 1; end
    run_dot("backpressure", 3, 1'b0, 10, 32'd3, 12);

    va[0] = 7; va[1] = -1;
    vb[0] = 6; vb[1] = 9;
    run_dot("second", 2, 1'b0, 0, 32'd33, 11);

    // reset in the middle of a 10-element stream
    @(negedge clk);
    pulses = 0;
    cmd_valid = 1'b1;
    cmd_len = 16'd10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    op_valid = 1'b1; op_a = 8'd5; op_b = 8'd5;
    k = 0;
    while (pulses < 5 && k < 50) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    chk("rstmid_reached", 32'(pulses >= 5), 32'd1);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    op_valid = 1'b0;
    #1;
    chk("rstmid_ctrl", {27'd0, cmd_ready, busy, op_ready, mac_in_valid, res_valid}, 32'b10000);
    chk("rstmid_mac_ab", {16'd0, mac_a, mac_b}, 32'd0);
    chk("rstmid_mac_acc", mac_acc, 32'd0);
    chk("rstmid_res_data", res_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    va[0] = 2; va[1] = 2;
    vb[0] = 3; vb[1] = 3;
    run_dot("after_rst", 2, 1'b0, 0, 32'd12, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
